// File: rtl/weight_rom_stream_ctrl.sv
// Weight ROM read sequencer: streams rows 0..OUT_DEPTH-1 for num_passes passes
// through a two-stage ROM into a credit-protected output FIFO with valid/ready.
module weight_rom_stream_ctrl #(
  parameter int OUT_DEPTH  = 32,
  parameter int ADDR_WIDTH = $clog2(OUT_DEPTH) + 1,
  parameter int DATA_WIDTH = 128,
  parameter int PASS_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_last,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [1:0]            state_dbg
);

  // Handshake: a row transfers on any rising edge where data_out_valid and
  // data_out_ready are both high; valid never drops until that transfer.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  done_nxt;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic [PASS_WIDTH-1:0] pass_cnt;
  logic [PASS_WIDTH-1:0] passes_q;
  logic                  v0, v1, l0, l1;
  logic                  issue, row_is_last, pass_is_last, accept_start;
  logic [SUM_W-1:0]      credit_used;

  logic [DATA_WIDTH-1:0] mem      [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push, pop;

  assign busy           = (state != S_IDLE);
  assign rom_ce         = busy;
  assign rom_addr       = row_cnt;
  assign state_dbg      = state;
  assign data_out_valid = (fifo_count != '0);
  assign data_out       = mem[rd_ptr];
  assign data_out_last  = data_out_valid && last_mem[rd_ptr];

  // Credits count buffered rows plus rows still inside the ROM pipeline.
  assign credit_used  = SUM_W'(fifo_count) + SUM_W'(v0) + SUM_W'(v1);
  assign issue        = (state == S_RUN) && (credit_used < SUM_W'(FIFO_DEPTH));
  assign row_is_last  = (row_cnt == ADDR_WIDTH'(OUT_DEPTH - 1));
  assign pass_is_last = (pass_cnt == passes_q - PASS_WIDTH'(1));
  assign accept_start = (state == S_IDLE) && start && (num_passes != '0);
  assign push         = rom_ce && v1;
  assign pop          = data_out_valid && data_out_ready;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_passes != '0) state_nxt = S_RUN;
          else                  done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (issue && row_is_last && pass_is_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!v0 && !v1 && (fifo_count == '0)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt  <= '0;
      pass_cnt <= '0;
      passes_q <= '0;
    end else if (accept_start) begin
      row_cnt  <= '0;
      pass_cnt <= '0;
      passes_q <= num_passes;
    end else if (issue) begin
      if (row_is_last) begin
        row_cnt  <= '0;
        pass_cnt <= pass_cnt + PASS_WIDTH'(1);
      end else begin
        row_cnt <= row_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // v0/l0 track the ROM address register, v1/l1 its output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else if (rom_ce) begin
      v0 <= issue;
      l0 <= issue && row_is_last;
      v1 <= v0;
      l1 <= l0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= rom_q;
      last_mem[wr_ptr] <= l1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// Bench for weight_rom_stream_ctrl: ROM model, expected-row queue, monitor
// comparing every handshake and done pulse, directed and random runs.
module tb_weight_rom_stream_ctrl;

  localparam int OUT_DEPTH  = 4;
  localparam int ADDR_WIDTH = $clog2(OUT_DEPTH) + 1;
  localparam int DATA_WIDTH = 128;
  localparam int PASS_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [PASS_WIDTH-1:0] num_passes;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_last;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [1:0]            state_dbg;

  weight_rom_stream_ctrl #(
    .OUT_DEPTH (OUT_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .PASS_WIDTH(PASS_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_passes    (num_passes),
    .busy          (busy),
    .done          (done),
    .rom_addr      (rom_addr),
    .rom_ce        (rom_ce),
    .rom_q         (rom_q),
    .data_out      (data_out),
    .data_out_last (data_out_last),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model: two registered stages gated by ce ----------------
  function automatic logic [DATA_WIDTH-1:0] row_data(input int r);
    logic [31:0] rr;
    rr = r;
    return {rr * 32'h9E3779B1, ~rr, 32'hC0DE0000 | rr, rr ^ 32'h5A5A5A5A};
  endfunction

  logic [ADDR_WIDTH-1:0] rom_a;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_a <= rom_addr;
      rom_q <= row_data(int'(rom_a));
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_WIDTH:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int last_cnt = 0;
  int last_hs = 0;
  int start_cyc = 0;
  bit zero_run = 0;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: held low

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic push_expected(input int n);
    for (int p = 0; p < n; p++)
      for (int r = 0; r < OUT_DEPTH; r++)
        exp_q.push_back({(r == OUT_DEPTH - 1), row_data(r)});
  endtask

  // ---------------- monitor: drives ready, pops/compares, checks done ----------------
  initial begin
    logic [DATA_WIDTH:0] e;
    data_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = 1'($urandom_range(0, 1));
        default: data_out_ready = 1'b0;
      endcase
      if (data_out_valid && data_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row: got last=%0b data=%h with empty queue", data_out_last, data_out);
        end else begin
          e = exp_q.pop_front();
          if ({data_out_last, data_out} !== e) begin
            errors++;
            $display("FAIL row: got last=%0b data=%h expected last=%0b data=%h",
                     data_out_last, data_out, e[DATA_WIDTH], e[DATA_WIDTH-1:0]);
          end
        end
        hs_cnt++;
        if (data_out_last) last_cnt++;
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (zero_run) begin
          if (cyc != start_cyc + 1 || busy) begin
            errors++;
            $display("FAIL done_zero: got cycle %0d busy %0b expected cycle %0d busy 0", cyc, busy, start_cyc + 1);
          end
        end else if (cyc != last_hs + 2 || exp_q.size() != 0 || busy) begin
          errors++;
          $display("FAIL done_timing: got cycle %0d busy %0b pending %0d expected cycle %0d busy 0 pending 0",
                   cyc, busy, exp_q.size(), last_hs + 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected one pulse", budget);
    end
    repeat (3) tick();
    check("done_once", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic run_passes(input int n, input int inject);
    int d0 = done_cnt;
    zero_run = (n == 0);
    push_expected(n);
    start = 1'b1;
    num_passes = PASS_WIDTH'(n);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    if (n == 0) check("zero_busy", 64'(busy), 64'd0);
    if (inject > 0) begin
      repeat (inject) tick();
      check("busy_at_inject", 64'(busy), 64'd1);
      start = 1'b1;
      num_passes = PASS_WIDTH'(5);
      tick();
      start = 1'b0;
    end
    wait_done(d0, n * OUT_DEPTH * 10 + 50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, n, lc0, hs0;
    rst = 1'b0;
    start = 1'b0;
    num_passes = '0;
    ready_mode = 0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rom_ce", 64'(rom_ce), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_valid", 64'(data_out_valid), 64'd0);
    check("rst_last", 64'(data_out_last), 64'd0);
    rst = 1'b1;
    repeat (3) tick();
    check("idle_rom_ce", 64'(rom_ce), 64'd0);
    check("idle_valid", 64'(data_out_valid), 64'd0);

    // single pass, ready high: first valid after the third edge past start
    ready_mode = 0;
    zero_run = 0;
    d0 = done_cnt;
    lc0 = last_cnt;
    hs0 = hs_cnt;
    push_expected(1);
    start = 1'b1;
    num_passes = PASS_WIDTH'(1);
    tick();
    start = 1'b0;
    check("lat_busy_e0", 64'(busy), 64'd1);
    check("lat_valid_e0", 64'(data_out_valid), 64'd0);
    tick();
    check("lat_valid_e1", 64'(data_out_valid), 64'd0);
    tick();
    check("lat_valid_e2", 64'(data_out_valid), 64'd0);
    tick();
    check("lat_valid_e3", 64'(data_out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stream_valid", 64'(data_out_valid), 64'd1);
    end
    wait_done(d0, 50);
    check("single_rows", 64'(hs_cnt - hs0), 64'(OUT_DEPTH));
    check("single_lasts", 64'(last_cnt - lc0), 64'd1);

    // backpressure: ready low while the FIFO fills
    ready_mode = 2;
    d0 = done_cnt;
    lc0 = last_cnt;
    push_expected(2);
    start = 1'b1;
    num_passes = PASS_WIDTH'(2);
    tick();
    start = 1'b0;
    n = 0;
    while (!data_out_valid && n < 10) begin
      tick();
      n++;
    end
    check("bp_first_valid", 64'(data_out_valid), 64'd1);
    repeat (10) tick();
    check("bp_held_valid", 64'(data_out_valid), 64'd1);
    check("bp_stalled_addr", 64'(rom_addr), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    ready_mode = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      tick();
      check("bp_drain_valid", 64'(data_out_valid), 64'd1);
    end
    wait_done(d0, 100);
    check("bp_lasts", 64'(last_cnt - lc0), 64'd2);

    // zero passes: done next cycle, no reads
    run_passes(0, 0);
    zero_run = 0;

    // random ready, long run with an ignored start, then random runs
    ready_mode = 1;
    run_passes(24, 10);
    for (int k = 0; k < 3; k++) run_passes($urandom_range(1, 6), 0);

    // reset mid-run clears everything at once; the next run restarts at row 0
    push_expected(3);
    start = 1'b1;
    num_passes = PASS_WIDTH'(3);
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rom_ce", 64'(rom_ce), 64'd0);
    check("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("mid_rst_valid", 64'(data_out_valid), 64'd0);
    check("mid_rst_last", 64'(data_out_last), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_rst_rom_ce", 64'(rom_ce), 64'd0);
    check("post_rst_valid", 64'(data_out_valid), 64'd0);
    ready_mode = 0;
    run_passes(1, 0);

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
